// File: rtl/uart_pkg.sv
// Shared state encoding and bit-timing constants for the UART transmit path.
package uart_pkg;

  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    BRK_LOW   = 3'd5,
    BRK_GUARD = 3'd6
  } tx_state_e;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Byte/break request side and serial line of the UART transmit controller.
interface uart_tx_frame_ctrl_if;

  logic [7:0] TX_Data;
  logic       TX_Valid;
  logic       TX_Ready;
  logic       Break_Req;
  logic       Break_Done;
  logic       Busy;
  logic       TX_Out;

  modport master (
    output TX_Data, TX_Valid, Break_Req,
    input  TX_Ready, Break_Done, Busy, TX_Out
  );

  modport slave (
    input  TX_Data, TX_Valid, Break_Req,
    output TX_Ready, Break_Done, Busy, TX_Out
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Counts 16x-baud strobes and flags the strobe that closes a bit-time.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic strobe_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (strobe_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = strobe_i & (cnt_q == LAST_TICK);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit sequencer: 8-bit frames with optional even parity and 1/2 stop
// bits, plus a long-break (comm-clear) generator with a one-bit guard time.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int C_STOP_BITS  = 1,
  parameter int C_PARITY_EN  = 0,
  parameter int C_BREAK_BITS = 11
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 EN_16x_Baud,
  uart_tx_frame_ctrl_if.slave  bus
);

  localparam logic       PAR_EN    = (C_PARITY_EN != 0);
  localparam logic [7:0] STOP_LAST = 8'(C_STOP_BITS - 1);
  localparam logic [7:0] BRK_LAST  = 8'(C_BREAK_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       tmr_clr;

  // Tick counter is held at zero while idle so every accept starts a fresh bit.
  assign tmr_clr = (state_q == IDLE);

  uart_bit_timer u_bit_timer (
    .Clk       (Clk),
    .Reset     (Reset),
    .strobe_i  (EN_16x_Baud),
    .clr_i     (tmr_clr),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Break_Req) begin
          state_d = BRK_LOW;
          tx_d    = 1'b0;
          cnt_d   = '0;
        end else if (bus.TX_Valid) begin
          data_d  = bus.TX_Data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            if (PAR_EN) begin
              state_d = PARITY;
              tx_d    = even_parity(data_q);
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
              cnt_d   = '0;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      STOP: begin
        // Leaving STOP lands in IDLE, where the next byte can be taken at once.
        if (bit_end) begin
          if (cnt_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      BRK_LOW: begin
        if (bit_end) begin
          if (cnt_q == BRK_LAST) begin
            state_d = BRK_GUARD;
            tx_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      BRK_GUARD: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge Clk) begin
    data_q <= data_d;
  end

  assign bus.TX_Ready   = (state_q == IDLE);
  assign bus.Busy       = (state_q != IDLE);
  assign bus.TX_Out     = tx_q;
  assign bus.Break_Done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: an 8N1 instance and an 8E2 instance share one
// clock and a 16x strobe every 4 Clk; line levels are compared at bit centres.
module tb_uart_tx_frame_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       en_gate = 1'b1;
  logic [1:0] div_q = 2'd0;
  logic       EN_16x_Baud;

  int checks = 0;
  int errors = 0;

  logic [7:0] d_s;
  logic       v_s;
  logic       b_s;

  bit           exp_q[$];
  logic [7:0]   src_q[$];

  uart_tx_frame_ctrl_if bus0 ();
  uart_tx_frame_ctrl_if bus1 ();

  uart_tx_frame_ctrl #(.C_STOP_BITS(1), .C_PARITY_EN(0), .C_BREAK_BITS(11)) dut0 (
    .Clk(Clk), .Reset(Reset), .EN_16x_Baud(EN_16x_Baud), .bus(bus0.slave)
  );

  uart_tx_frame_ctrl #(.C_STOP_BITS(2), .C_PARITY_EN(1), .C_BREAK_BITS(11)) dut1 (
    .Clk(Clk), .Reset(Reset), .EN_16x_Baud(EN_16x_Baud), .bus(bus1.slave)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (en_gate) div_q <= div_q + 2'd1;
  end
  assign EN_16x_Baud = en_gate & (div_q == 2'd3);

  function automatic logic obs_tx(input int sel);
    return (sel == 0) ? bus0.TX_Out : bus1.TX_Out;
  endfunction
  function automatic logic obs_rdy(input int sel);
    return (sel == 0) ? bus0.TX_Ready : bus1.TX_Ready;
  endfunction
  function automatic logic obs_busy(input int sel);
    return (sel == 0) ? bus0.Busy : bus1.Busy;
  endfunction
  function automatic logic obs_done(input int sel);
    return (sel == 0) ? bus0.Break_Done : bus1.Break_Done;
  endfunction

  task automatic drive(input int sel);
    bus0.TX_Data   = (sel == 0) ? d_s : 8'h00;
    bus0.TX_Valid  = (sel == 0) & v_s;
    bus0.Break_Req = (sel == 0) & b_s;
    bus1.TX_Data   = (sel == 1) ? d_s : 8'h00;
    bus1.TX_Valid  = (sel == 1) & v_s;
    bus1.Break_Req = (sel == 1) & b_s;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1s.
  function automatic void push_frame(input logic [7:0] d, input bit par, input int stops);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par) exp_q.push_back((ones % 2) == 1);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endfunction

  function automatic void push_break(input int bits);
    for (int i = 0; i < bits; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
  endfunction

  // Plays src_q (and optionally a break) into one DUT and samples each bit
  // centre against exp_q; strobe-time (ec) freezes while the strobe is gated.
  task automatic run(input int sel, input bit with_break, input int frames,
                     input int hold_at, input int hold_len, input string tag);
    int   n, budget, ec, k, last_rdy, done_n, done_c;
    bit   pend_acc;
    logic prev_rdy;
    n = exp_q.size();
    budget = 64 * n + 80;
    ec = 0; k = 0; last_rdy = -1; done_n = 0; done_c = -1;
    prev_rdy = 1'b1;
    @(negedge Clk);
    chk({tag, "_rdy_start"}, obs_rdy(sel), 1);
    b_s = with_break;
    v_s = (src_q.size() > 0);
    d_s = v_s ? src_q[0] : 8'h00;
    drive(sel);
    pend_acc = v_s & ~with_break;
    for (int c = 1; c <= budget + hold_len; c++) begin
      @(negedge Clk);
      if (en_gate) ec++;
      if (hold_len > 0 && c == hold_at) en_gate = 1'b0;
      if (hold_len > 0 && c == hold_at + hold_len) begin
        chk({tag, "_stall_tx"}, obs_tx(sel), 0);
        chk({tag, "_stall_busy"}, obs_busy(sel), 1);
        en_gate = 1'b1;
      end
      if (pend_acc) begin
        pend_acc = 1'b0;
        void'(src_q.pop_front());
        v_s = (src_q.size() > 0);
        d_s = v_s ? src_q[0] : 8'h00;
        drive(sel);
      end
      if (obs_done(sel)) begin
        done_n++;
        done_c = ec;
        b_s = 1'b0;
        drive(sel);
      end
      if (obs_rdy(sel) && !prev_rdy) last_rdy = ec;
      prev_rdy = obs_rdy(sel);
      if (obs_rdy(sel) && v_s && !b_s) pend_acc = 1'b1;
      if (k < n && ec == 64 * k + 32) begin
        chk($sformatf("%s_bit%0d", tag, k), obs_tx(sel), exp_q[k]);
        chk($sformatf("%s_busy%0d", tag, k), obs_busy(sel), 1);
        k++;
      end
    end
    chk({tag, "_all_bits"}, k, n);
    chk({tag, "_end_rdy"}, obs_rdy(sel), 1);
    chk({tag, "_end_busy"}, obs_busy(sel), 0);
    chk({tag, "_end_tx"}, obs_tx(sel), 1);
    chk({tag, "_consumed"}, src_q.size(), 0);
    chk_rng({tag, "_frame_len"}, last_rdy, 64 * n - 4 * frames, 64 * n + frames);
    chk({tag, "_done_cnt"}, done_n, with_break ? 1 : 0);
    if (with_break) chk_rng({tag, "_done_time"}, done_c, 64 * 12 - 4, 64 * 12 + 1);
    exp_q.delete();
    src_q.delete();
    d_s = 8'h00; v_s = 1'b0; b_s = 1'b0;
    drive(sel);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] rb2;
    Reset = 1'b1;
    d_s = 8'h00; v_s = 1'b0; b_s = 1'b0;
    drive(0);
    repeat (3) @(negedge Clk);
    chk("rst_tx0", bus0.TX_Out, 1);
    chk("rst_rdy0", bus0.TX_Ready, 1);
    chk("rst_busy0", bus0.Busy, 0);
    chk("rst_done0", bus0.Break_Done, 0);
    chk("rst_tx1", bus1.TX_Out, 1);
    chk("rst_rdy1", bus1.TX_Ready, 1);
    chk("rst_busy1", bus1.Busy, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    push_frame(8'h55, 1'b0, 1);
    src_q.push_back(8'h55);
    run(0, 1'b0, 1, 0, 0, "t1_55");

    push_frame(8'hA5, 1'b0, 1);
    push_frame(8'h3C, 1'b0, 1);
    src_q.push_back(8'hA5);
    src_q.push_back(8'h3C);
    run(0, 1'b0, 2, 0, 0, "t2_b2b");

    push_frame(8'h07, 1'b1, 2);
    src_q.push_back(8'h07);
    run(1, 1'b0, 1, 0, 0, "t3_par");

    rb = 8'($urandom);
    push_break(11);
    push_frame(rb, 1'b0, 1);
    src_q.push_back(rb);
    run(0, 1'b1, 2, 0, 0, "t4_brk");

    // Abort mid-frame with reset, then a clean 0xFF.
    rb = 8'($urandom);
    @(negedge Clk);
    d_s = rb; v_s = 1'b1; b_s = 1'b0;
    drive(0);
    @(negedge Clk);
    v_s = 1'b0;
    drive(0);
    repeat (64 * 4 + 30) @(negedge Clk);
    chk("t5_mid_busy", bus0.Busy, 1);
    chk("t5_mid_bit3", bus0.TX_Out, rb[3]);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("t5_rst_tx", bus0.TX_Out, 1);
    chk("t5_rst_rdy", bus0.TX_Ready, 1);
    chk("t5_rst_busy", bus0.Busy, 0);
    push_frame(8'hFF, 1'b0, 1);
    src_q.push_back(8'hFF);
    run(0, 1'b0, 1, 0, 0, "t5_ff");

    rb = 8'($urandom);
    push_frame(rb, 1'b0, 1);
    src_q.push_back(rb);
    run(0, 1'b0, 1, 32, 500, "t6_stall");

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      push_frame(rb, 1'b0, 1);
      src_q.push_back(rb);
      run(0, 1'b0, 1, 0, 0, $sformatf("r0_%0d", i));
      rb = 8'($urandom);
      push_frame(rb, 1'b1, 2);
      src_q.push_back(rb);
      run(1, 1'b0, 1, 0, 0, $sformatf("r1_%0d", i));
    end

    rb = 8'($urandom);
    rb2 = 8'($urandom);
    push_frame(rb, 1'b0, 1);
    push_frame(rb2, 1'b0, 1);
    push_frame(~rb, 1'b0, 1);
    src_q.push_back(rb);
    src_q.push_back(rb2);
    src_q.push_back(~rb);
    run(0, 1'b0, 3, 0, 0, "r0_b2b3");

    rb = 8'($urandom);
    push_break(11);
    push_frame(rb, 1'b1, 2);
    src_q.push_back(rb);
    run(1, 1'b1, 2, 0, 0, "r1_brk");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
